// File: rtl/fifo_ctrl_pkg.sv
// Shared state encoding and width helpers for the multi-FIFO control FSM.
package fifo_ctrl_pkg;

  localparam int STATE_W = 5;

  localparam logic [STATE_W-1:0] ST_RESET  = 5'b00001;
  localparam logic [STATE_W-1:0] ST_INIT   = 5'b00010;
  localparam logic [STATE_W-1:0] ST_IDLE   = 5'b00100;
  localparam logic [STATE_W-1:0] ST_ACTIVE = 5'b01000;
  localparam logic [STATE_W-1:0] ST_ERROR  = 5'b10000;

  // Counter must be able to hold IDLE_CYC itself so it can saturate cleanly.
  function automatic int idle_cnt_width(input int idle_cyc);
    return $clog2(idle_cyc + 1);
  endfunction

  function automatic int err_id_width(input int num_fifos);
    return (num_fifos > 1) ? $clog2(num_fifos) : 1;
  endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit, zero when no bit is set.
module lowest_set_idx #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx
);

  // Scanning downwards lets the lowest set bit overwrite any higher one.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/fifo_ctrl_fsm.sv
// Control FSM for the multi-FIFO datapath: threshold load/check, idle tracking
// with timeout, and sticky per-FIFO error capture.
module fifo_ctrl_fsm
  import fifo_ctrl_pkg::*;
#(
  parameter int NUM_FIFOS = 4,
  parameter int THR_W     = 5,
  parameter int IDLE_CYC  = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                init,
  input  logic [THR_W-1:0]                    cfg_almost_full,
  input  logic [THR_W-1:0]                    cfg_almost_empty,
  input  logic [NUM_FIFOS-1:0]                fifo_empty,
  input  logic [NUM_FIFOS-1:0]                fifo_error,
  input  logic                                err_clear,
  output logic [THR_W-1:0]                    thr_almost_full,
  output logic [THR_W-1:0]                    thr_almost_empty,
  output logic                                init_out,
  output logic                                idle_out,
  output logic                                active_out,
  output logic                                error_out,
  output logic                                cfg_err,
  output logic [NUM_FIFOS-1:0]                err_vector,
  output logic [err_id_width(NUM_FIFOS)-1:0]  err_id
);

  localparam int CNT_W = idle_cnt_width(IDLE_CYC);
  localparam int ID_W  = err_id_width(NUM_FIFOS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IDLE_CYC - 1);

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   idle_cnt;
  logic [ID_W-1:0]    first_err;
  logic               any_err;
  logic               all_empty;

  assign any_err   = |fifo_error;
  assign all_empty = &fifo_empty;

  lowest_set_idx #(
    .N (NUM_FIFOS),
    .W (ID_W)
  ) u_lowest_set_idx (
    .vec (fifo_error),
    .idx (first_err)
  );

  // idle_cnt defaults to zero so it only survives consecutive all-empty ACTIVE cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_RESET;
      thr_almost_full  <= '0;
      thr_almost_empty <= '0;
      cfg_err          <= 1'b0;
      err_vector       <= '0;
      err_id           <= '0;
      idle_cnt         <= '0;
    end else begin
      idle_cnt <= '0;
      case (state)
        ST_RESET: state <= ST_INIT;

        ST_INIT: begin
          if (init) begin
            thr_almost_full  <= cfg_almost_full;
            thr_almost_empty <= cfg_almost_empty;
          end else if (thr_almost_empty >= thr_almost_full) begin
            state      <= ST_ERROR;
            cfg_err    <= 1'b1;
            err_vector <= '0;
            err_id     <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end

        ST_IDLE: begin
          if (init) begin
            state <= ST_INIT;
          end else if (any_err) begin
            state      <= ST_ERROR;
            err_vector <= fifo_error;
            err_id     <= first_err;
          end else if (!all_empty) begin
            state <= ST_ACTIVE;
          end
        end

        ST_ACTIVE: begin
          if (init) begin
            state <= ST_INIT;
          end else if (any_err) begin
            state      <= ST_ERROR;
            err_vector <= fifo_error;
            err_id     <= first_err;
          end else if (all_empty) begin
            if (idle_cnt == CNT_LAST) begin
              state <= ST_IDLE;
            end else if (idle_cnt != '1) begin
              idle_cnt <= idle_cnt + 1'b1;
            end
          end
        end

        ST_ERROR: begin
          if (err_clear && !any_err) begin
            state      <= ST_INIT;
            err_vector <= '0;
            err_id     <= '0;
            cfg_err    <= 1'b0;
          end else begin
            err_vector <= err_vector | fifo_error;
          end
        end

        default: state <= ST_RESET;
      endcase
    end
  end

  assign init_out   = (state == ST_INIT);
  assign idle_out   = (state == ST_IDLE);
  assign active_out = (state == ST_ACTIVE);
  assign error_out  = (state == ST_ERROR);

endmodule

// File: tb/tb_fifo_ctrl_fsm.sv
// Self-checking bench for fifo_ctrl_fsm: directed vector table, idle-timeout
// sequences, and randomized traffic against a behavioural reference model.
module tb_fifo_ctrl_fsm;

  localparam int IDLE_CYC = 8;

  localparam logic [3:0] RST = 4'b0000;
  localparam logic [3:0] INI = 4'b0001;
  localparam logic [3:0] IDL = 4'b0010;
  localparam logic [3:0] ACT = 4'b0100;
  localparam logic [3:0] ERR = 4'b1000;
  localparam logic [3:0] E   = 4'b1111;

  logic       clk = 1'b0;
  logic       reset, init, err_clear;
  logic [4:0] cfg_almost_full, cfg_almost_empty;
  logic [3:0] fifo_empty, fifo_error;
  logic [4:0] thr_almost_full, thr_almost_empty;
  logic       init_out, idle_out, active_out, error_out, cfg_err;
  logic [3:0] err_vector;
  logic [1:0] err_id;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_ctrl_fsm #(
    .NUM_FIFOS (4),
    .THR_W     (5),
    .IDLE_CYC  (IDLE_CYC)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .init             (init),
    .cfg_almost_full  (cfg_almost_full),
    .cfg_almost_empty (cfg_almost_empty),
    .fifo_empty       (fifo_empty),
    .fifo_error       (fifo_error),
    .err_clear        (err_clear),
    .thr_almost_full  (thr_almost_full),
    .thr_almost_empty (thr_almost_empty),
    .init_out         (init_out),
    .idle_out         (idle_out),
    .active_out       (active_out),
    .error_out        (error_out),
    .cfg_err          (cfg_err),
    .err_vector       (err_vector),
    .err_id           (err_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, ini;
    logic [4:0] af, ae;
    logic [3:0] emp, err;
    logic       clr;
    logic [3:0] ind;
    logic       cfg;
    logic [3:0] vec;
    logic [1:0] id;
    logic [4:0] taf, tae;
  } vec_t;

  vec_t tbl[$];

  typedef enum int {M_RESET, M_INIT, M_IDLE, M_ACTIVE, M_ERROR} mode_t;
  mode_t      m_mode;
  logic [4:0] m_af, m_ae;
  logic       m_cfg;
  logic [3:0] m_vec;
  logic [1:0] m_id;
  int         m_run;

  task automatic addRow(input logic rst, input logic ini, input logic [4:0] af,
                        input logic [4:0] ae, input logic [3:0] emp, input logic [3:0] err,
                        input logic clr, input logic [3:0] ind, input logic cfg,
                        input logic [3:0] vec, input logic [1:0] id,
                        input logic [4:0] taf, input logic [4:0] tae);
    vec_t r;
    r.rst = rst; r.ini = ini; r.af = af; r.ae = ae; r.emp = emp; r.err = err;
    r.clr = clr; r.ind = ind; r.cfg = cfg; r.vec = vec; r.id = id;
    r.taf = taf; r.tae = tae;
    tbl.push_back(r);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input vec_t r);
    reset = r.rst; init = r.ini; cfg_almost_full = r.af; cfg_almost_empty = r.ae;
    fifo_empty = r.emp; fifo_error = r.err; err_clear = r.clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] indicators();
    return {error_out, active_out, idle_out, init_out};
  endfunction

  function automatic logic [1:0] lowestIdx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return 2'(i);
    return 2'd0;
  endfunction

  // Reference: counts consecutive all-empty ACTIVE cycles and leaves once IDLE_CYC are seen.
  task automatic modelStep();
    if (reset) begin
      m_mode = M_RESET; m_af = 0; m_ae = 0; m_cfg = 0; m_vec = 0; m_id = 0; m_run = 0;
    end else begin
      case (m_mode)
        M_RESET: m_mode = M_INIT;
        M_INIT:
          if (init) begin m_af = cfg_almost_full; m_ae = cfg_almost_empty; end
          else if (m_ae >= m_af) begin m_mode = M_ERROR; m_cfg = 1; m_vec = 0; m_id = 0; end
          else m_mode = M_IDLE;
        M_IDLE, M_ACTIVE:
          if (init) m_mode = M_INIT;
          else if (fifo_error != 0) begin
            m_mode = M_ERROR; m_vec = fifo_error; m_id = lowestIdx(fifo_error);
          end else if (m_mode == M_IDLE) begin
            if (fifo_empty != 4'hF) begin m_mode = M_ACTIVE; m_run = 0; end
          end else if (fifo_empty == 4'hF) begin
            m_run++;
            if (m_run == IDLE_CYC) m_mode = M_IDLE;
          end else m_run = 0;
        M_ERROR:
          if (err_clear && fifo_error == 0) begin
            m_mode = M_INIT; m_vec = 0; m_id = 0; m_cfg = 0;
          end else m_vec = m_vec | fifo_error;
        default: m_mode = M_RESET;
      endcase
    end
  endtask

  function automatic logic [3:0] modelInd();
    case (m_mode)
      M_INIT:   return INI;
      M_IDLE:   return IDL;
      M_ACTIVE: return ACT;
      M_ERROR:  return ERR;
      default:  return RST;
    endcase
  endfunction

  // From IDLE: one non-empty cycle enters ACTIVE, then count edges until IDLE reappears.
  task automatic runTimeout(input int blip_at, input int exp_edges, input string name);
    int n = 0;
    init = 0; fifo_error = 0; err_clear = 0; reset = 0;
    fifo_empty = 4'b1011;
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " enter"}, 32'(indicators()), 32'(ACT));
    while (!idle_out && n < 40) begin
      fifo_empty = (n == blip_at) ? 4'b1110 : 4'b1111;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    checkOutput({name, " edges"}, 32'(n), 32'(exp_edges));
  endtask

  initial begin
    addRow(1,0,20,4,E,4'b0000,0, RST,0,4'b0000,0, 0, 0);
    addRow(0,1,20,4,E,4'b0000,0, INI,0,4'b0000,0, 0, 0);
    addRow(0,1,20,4,E,4'b0000,0, INI,0,4'b0000,0,20, 4);
    addRow(0,1,20,4,E,4'b0000,0, INI,0,4'b0000,0,20, 4);
    addRow(0,0,20,4,E,4'b0000,0, IDL,0,4'b0000,0,20, 4);
    addRow(0,0,20,4,4'b1011,4'b0000,0, ACT,0,4'b0000,0,20, 4);
    addRow(0,0,20,4,E,4'b0100,0, ERR,0,4'b0100,2,20, 4);
    addRow(0,0,20,4,E,4'b0001,0, ERR,0,4'b0101,2,20, 4);
    addRow(0,0,20,4,E,4'b0010,1, ERR,0,4'b0111,2,20, 4);
    addRow(0,0,20,4,E,4'b0000,1, INI,0,4'b0000,0,20, 4);
    addRow(0,0,20,4,E,4'b0000,0, IDL,0,4'b0000,0,20, 4);
    addRow(0,0,20,4,4'b0111,4'b0000,0, ACT,0,4'b0000,0,20, 4);
    addRow(0,1, 3,3,E,4'b0001,0, INI,0,4'b0000,0,20, 4);
    addRow(0,1, 3,3,E,4'b0000,0, INI,0,4'b0000,0, 3, 3);
    addRow(0,0, 3,3,E,4'b0010,0, ERR,1,4'b0000,0, 3, 3);
    addRow(0,1, 9,1,E,4'b0000,0, ERR,1,4'b0000,0, 3, 3);
    addRow(0,0, 9,1,E,4'b0000,1, INI,0,4'b0000,0, 3, 3);
    addRow(0,1, 9,1,E,4'b0000,0, INI,0,4'b0000,0, 9, 1);
    addRow(0,0, 9,1,E,4'b0000,0, IDL,0,4'b0000,0, 9, 1);
    addRow(0,0, 9,1,E,4'b1111,0, ERR,0,4'b1111,0, 9, 1);
    addRow(1,0, 9,1,E,4'b1111,0, RST,0,4'b0000,0, 0, 0);
    addRow(0,0, 9,1,E,4'b0000,0, INI,0,4'b0000,0, 0, 0);
    addRow(0,0, 9,1,E,4'b0000,0, ERR,1,4'b0000,0, 0, 0);
    addRow(0,0, 5,4,E,4'b0000,1, INI,0,4'b0000,0, 0, 0);
    addRow(0,1, 5,4,E,4'b0000,0, INI,0,4'b0000,0, 5, 4);
    addRow(0,0, 5,4,E,4'b0000,0, IDL,0,4'b0000,0, 5, 4);

    @(negedge clk);
    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      checkOutput($sformatf("row%0d state", i),  32'(indicators()), 32'(tbl[i].ind));
      checkOutput($sformatf("row%0d cfg_err", i), 32'(cfg_err), 32'(tbl[i].cfg));
      checkOutput($sformatf("row%0d err_vector", i), 32'(err_vector), 32'(tbl[i].vec));
      checkOutput($sformatf("row%0d err_id", i), 32'(err_id), 32'(tbl[i].id));
      checkOutput($sformatf("row%0d thr", i), 32'({thr_almost_full, thr_almost_empty}),
                  32'({tbl[i].taf, tbl[i].tae}));
    end

    runTimeout(-1, IDLE_CYC, "timeout plain");
    runTimeout(5, 14, "timeout blip");

    reset = 1; init = 0; err_clear = 0; fifo_error = 0; fifo_empty = 4'hF;
    cfg_almost_full = 0; cfg_almost_empty = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) begin
        reset            = ($urandom_range(0, 99) < 1);
        init             = ($urandom_range(0, 99) < 3);
        cfg_almost_full  = 5'($urandom);
        cfg_almost_empty = 5'($urandom);
        fifo_empty       = ($urandom_range(0, 99) < 85) ? 4'hF : 4'($urandom);
        fifo_error       = ($urandom_range(0, 99) < 3) ? 4'($urandom) : 4'h0;
        err_clear        = ($urandom_range(0, 99) < 25);
      end
      modelStep();
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("random cycle %0d", cyc),
                  32'({indicators(), cfg_err, err_vector, err_id, thr_almost_full, thr_almost_empty}),
                  32'({modelInd(), m_cfg, m_vec, m_id, m_af, m_ae}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
